// File: rtl/ifmap_pkg.sv
// Shared definitions for the tagged IFmap stream: tag codes, the sender FSM
// state encoding, and the tag-selection helper used by both the sender and
// the IF-side decoder.
package ifmap_pkg;

    localparam int TAG_W = 2;

    localparam logic [TAG_W-1:0] TAG_START  = 2'b10;
    localparam logic [TAG_W-1:0] TAG_MID    = 2'b00;
    localparam logic [TAG_W-1:0] TAG_END    = 2'b01;
    localparam logic [TAG_W-1:0] TAG_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // A word that is both first and last belongs to a one-word frame.
    function automatic logic [TAG_W-1:0] ifmap_tag(input logic first, input logic last);
        logic [TAG_W-1:0] tag;
        if (first && last) begin
            tag = TAG_SINGLE;
        end else if (first) begin
            tag = TAG_START;
        end else if (last) begin
            tag = TAG_END;
        end else begin
            tag = TAG_MID;
        end
        return tag;
    endfunction

endpackage

// File: rtl/ifmap_tag_sender_if.sv
// Stream bundle between a raw IFmap source, the tag sender and the IF buffer
// write port.
//
// Handshake: a source word moves when src_valid && src_ready are both high on
// a rising clk edge. The source holds src_data stable while src_valid is high
// and src_ready is low. On the buffer side IF_wen is a plain write strobe;
// the sender never raises it while IF_full is high, and IF_din is 0 whenever
// IF_wen is 0.
interface ifmap_tag_sender_if #(
    parameter int W = 16
);
    import ifmap_pkg::*;

    logic             src_valid;
    logic [W-1:0]     src_data;
    logic             src_ready;
    logic             IF_full;
    logic             IF_wen;
    logic [W+TAG_W-1:0] IF_din;

    // Sender side: consumes the source, drives the buffer write port.
    modport master (
        input  src_valid,
        input  src_data,
        output src_ready,
        input  IF_full,
        output IF_wen,
        output IF_din
    );

    // Environment side: supplies source words and buffer status.
    modport slave (
        output src_valid,
        output src_data,
        input  src_ready,
        output IF_full,
        input  IF_wen,
        input  IF_din
    );

endinterface

// File: rtl/ifmap_tag_sender.sv
// Frames raw IFmap words from a valid/ready source into the tagged IF buffer
// stream. Each word gets a 2-bit frame tag prepended and is written in the
// same cycle it is accepted, so the buffer full flag back-pressures the
// source directly with no skid storage.
module ifmap_tag_sender
    import ifmap_pkg::*;
#(
    parameter int IF_SCRATCH_WIDTH = 16,
    parameter int IF_par_write     = 1,
    parameter int LEN_W            = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     frame_len,
    ifmap_tag_sender_if.master   bus,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           dbg_state
);

    generate
        if (IF_par_write != 1) begin : g_bad_par_write
            $error("ifmap_tag_sender: only IF_par_write == 1 is supported");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             first_q, first_d;
    logic             xfer;
    logic             last_word;

    assign dbg_state = state_q;
    assign last_word = (rem_q == LEN_W'(1));

    // State, remaining-word count and first-word flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            first_q <= first_d;
        end
    end

    // Next-state logic and all outputs; the write path is combinational so a
    // transfer and its buffer write happen in the same cycle.
    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        first_d       = first_q;
        busy          = 1'b0;
        done          = 1'b0;
        xfer          = 1'b0;
        bus.src_ready = 1'b0;
        bus.IF_wen    = 1'b0;
        bus.IF_din    = '0;

        case (state_q)
            S_IDLE: begin
                // A zero-length start is dropped silently.
                if (start && (frame_len != '0)) begin
                    rem_d   = frame_len;
                    first_d = 1'b1;
                    state_d = S_SEND;
                end
            end

            S_SEND: begin
                busy          = 1'b1;
                bus.src_ready = !bus.IF_full;
                xfer          = bus.src_valid && !bus.IF_full;
                if (xfer) begin
                    bus.IF_wen = 1'b1;
                    bus.IF_din = {ifmap_tag(first_q, last_word), bus.src_data};
                    rem_d      = rem_q - LEN_W'(1);
                    first_d    = 1'b0;
                    if (last_word) begin
                        state_d = S_FIN;
                    end
                end
            end

            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ifmap_tag_sender.sv
// Directed bench for ifmap_tag_sender: full frame, back-pressure, source
// gaps, one- and zero-length frames, start abuse and mid-frame reset.
module tb_ifmap_tag_sender;
    import ifmap_pkg::*;

    localparam int W     = 16;
    localparam int LEN_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    ifmap_tag_sender_if #(.W(W)) bus ();

    ifmap_tag_sender #(
        .IF_SCRATCH_WIDTH(W),
        .IF_par_write    (1),
        .LEN_W           (LEN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .frame_len(frame_len),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .dbg_state(dbg_state)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W-1:0]   cur_w   [16];
    logic [W+1:0]   exp_cur [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame of n words from cur_w, comparing every write to exp_cur.
    // stall_at: IF_full goes high for stall_len cycles once that many words
    // are written (-1 = never). gap: src_valid only on even cycles.
    // abuse_at: a start with frame_len=3 is pulsed when that many words are
    // written (-1 = never). span_exp: cycles from first to last write inclusive.
    task automatic run_frame(input int n, input int stall_at, input int stall_len,
                             input bit gap, input int abuse_at, input int span_exp);
        int idx = 0;
        int cycles = 0;
        int stall_rem = 0;
        int writes = 0;
        int first_cyc = -1;
        int last_cyc = -1;
        bit full;
        bit valid;

        start     = 1'b1;
        frame_len = LEN_W'(n);
        #1;
        chk("idle_ready", 32'(bus.src_ready), 32'd0);
        cyc();
        start = 1'b0;

        while (idx < n && cycles < 100) begin
            full  = (stall_rem > 0);
            valid = gap ? (cycles % 2 == 0) : 1'b1;
            bus.IF_full   = full;
            bus.src_valid = valid;
            bus.src_data  = valid ? cur_w[idx] : W'($urandom);
            if (abuse_at >= 0 && idx == abuse_at) begin
                start     = 1'b1;
                frame_len = LEN_W'(3);
            end else begin
                start = 1'b0;
            end
            #1;
            chk("busy", 32'(busy), 32'd1);
            chk("src_ready", 32'(bus.src_ready), 32'(!full));
            chk("wen", 32'(bus.IF_wen), 32'(valid && !full));
            if (valid && !full) begin
                chk($sformatf("din[%0d]", idx), 32'(bus.IF_din), 32'(exp_cur[idx]));
            end else begin
                chk("din_idle", 32'(bus.IF_din), 32'd0);
            end
            if (bus.IF_wen) begin
                writes++;
                if (first_cyc < 0) first_cyc = cycles;
                last_cyc = cycles;
            end
            if (full) begin
                stall_rem--;
            end
            if (valid && !full) begin
                idx++;
                if (idx == stall_at) stall_rem = stall_len;
            end
            cyc();
            cycles++;
        end
        chk("frame_timeout", 32'(idx), 32'(n));
        chk("write_count", 32'(writes), 32'(n));
        chk("write_span", 32'(last_cyc - first_cyc + 1), 32'(span_exp));

        start         = 1'b0;
        bus.src_valid = 1'b0;
        bus.IF_full   = 1'b0;
        #1;
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_busy", 32'(busy), 32'd0);
        chk("fin_ready", 32'(bus.src_ready), 32'd0);
        chk("fin_wen", 32'(bus.IF_wen), 32'd0);
        chk("fin_state", 32'(dbg_state), 32'(S_FIN));
        cyc();
        #1;
        chk("post_done", 32'(done), 32'd0);
        chk("post_state", 32'(dbg_state), 32'(S_IDLE));
    endtask

    task automatic load_ten();
        cur_w[0] = 16'h0013; exp_cur[0] = 18'h20013;
        cur_w[1] = 16'hFFF0; exp_cur[1] = 18'h0FFF0;
        cur_w[2] = 16'h0011; exp_cur[2] = 18'h00011;
        cur_w[3] = 16'hFFBF; exp_cur[3] = 18'h0FFBF;
        cur_w[4] = 16'h0022; exp_cur[4] = 18'h00022;
        cur_w[5] = 16'hFFE0; exp_cur[5] = 18'h0FFE0;
        cur_w[6] = 16'h000D; exp_cur[6] = 18'h0000D;
        cur_w[7] = 16'hFFDE; exp_cur[7] = 18'h0FFDE;
        cur_w[8] = 16'h0015; exp_cur[8] = 18'h00015;
        cur_w[9] = 16'hFFFB; exp_cur[9] = 18'h1FFFB;
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        frame_len     = '0;
        bus.src_valid = 1'b0;
        bus.src_data  = '0;
        bus.IF_full   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cur_w[i]   = '0;
            exp_cur[i] = '0;
        end

        // Reset state.
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(bus.src_ready), 32'd0);
        chk("rst_wen", 32'(bus.IF_wen), 32'd0);
        chk("rst_din", 32'(bus.IF_din), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));

        // Ten-word frame, full throughput.
        load_ten();
        run_frame(10, -1, 0, 1'b0, -1, 10);

        // Back-pressure: IF_full high for 3 cycles after word 4.
        run_frame(10, 4, 3, 1'b0, -1, 13);

        // Source gaps: valid every other cycle.
        run_frame(10, -1, 0, 1'b1, -1, 19);

        // Single-word frame.
        cur_w[0]   = 16'h0007;
        exp_cur[0] = 18'h30007;
        run_frame(1, -1, 0, 1'b0, -1, 1);

        // Zero-length frame is ignored.
        start         = 1'b1;
        frame_len     = '0;
        cyc();
        start         = 1'b0;
        bus.src_valid = 1'b1;
        bus.src_data  = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("zero_busy", 32'(busy), 32'd0);
            chk("zero_wen", 32'(bus.IF_wen), 32'd0);
            chk("zero_done", 32'(done), 32'd0);
            cyc();
        end
        bus.src_valid = 1'b0;

        // Start pulsed mid-frame with frame_len=3 is ignored.
        load_ten();
        run_frame(10, -1, 0, 1'b0, 5, 10);

        // Reset after word 5.
        start     = 1'b1;
        frame_len = LEN_W'(10);
        cyc();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.src_valid = 1'b1;
            bus.src_data  = cur_w[i];
            #1;
            chk("pre_rst_wen", 32'(bus.IF_wen), 32'd1);
            chk("pre_rst_din", 32'(bus.IF_din), 32'(exp_cur[i]));
            cyc();
        end
        bus.src_valid = 1'b0;
        rst           = 1'b1;
        cyc();
        rst           = 1'b0;
        bus.src_valid = 1'b1;
        bus.src_data  = cur_w[5];
        #1;
        chk("after_rst_wen", 32'(bus.IF_wen), 32'd0);
        chk("after_rst_busy", 32'(busy), 32'd0);
        chk("after_rst_ready", 32'(bus.src_ready), 32'd0);
        chk("after_rst_done", 32'(done), 32'd0);
        chk("after_rst_state", 32'(dbg_state), 32'(S_IDLE));
        bus.src_valid = 1'b0;
        cyc();

        // Two-word frame after reset.
        exp_cur[0] = 18'h20013;
        exp_cur[1] = 18'h1FFF0;
        run_frame(2, -1, 0, 1'b0, -1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
